// File: rtl/alu_sequencer_if.sv
// Handshake, operand bus and ALU-side signals of the ALU sequencer.
// The master modport drives requests and the ALU result; the slave modport is the sequencer side.
interface alu_sequencer_if;
  logic        start;
  logic [3:0]  opcode;
  logic [31:0] bus_in;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctl;
  logic [63:0] alu_c;
  logic [31:0] z_lo;
  logic [31:0] z_hi;
  logic [31:0] bus_out;
  logic        bus_drive;
  logic        busy;
  logic        done;
  logic        err;
  logic        dz;

  modport master (
    output start, opcode, bus_in, alu_c,
    input  alu_a, alu_b, alu_ctl, z_lo, z_hi, bus_out, bus_drive, busy, done, err, dz
  );

  modport slave (
    input  start, opcode, bus_in, alu_c,
    output alu_a, alu_b, alu_ctl, z_lo, z_hi, bus_out, bus_drive, busy, done, err, dz
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation: loads operands from a shared bus, waits a per-opcode
// number of cycles, captures the 64-bit result and returns it over the bus.
module alu_sequencer #(
  parameter int MUL_WAIT = 4,
  parameter int DIV_WAIT = 32
) (
  input logic            clk,
  input logic            clr,
  alu_sequencer_if.slave bus
);

  localparam int MAX_WAIT = (MUL_WAIT > DIV_WAIT) ? MUL_WAIT : DIV_WAIT;
  localparam int CW       = $clog2(MAX_WAIT + 1);

  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd11;
  localparam logic [3:0] OP_NEG = 4'd12;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    EXEC,
    CAPTURE,
    OUT_LO,
    OUT_HI
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   a_reg, a_next;
  logic [31:0]   b_reg, b_next;
  logic [3:0]    ctl_reg, ctl_next;
  logic [63:0]   z_reg, z_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;
  logic          dz_reg, dz_next;
  logic          wide_out;

  function automatic logic op_valid(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd12);
  endfunction

  function automatic logic op_unary(input logic [3:0] op);
    return (op == OP_NOT) || (op == OP_NEG);
  endfunction

  function automatic logic [CW-1:0] wait_for(input logic [3:0] op);
    if (op == OP_MUL)      return CW'(MUL_WAIT);
    else if (op == OP_DIV) return CW'(DIV_WAIT);
    else                   return CW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      ctl_reg   <= '0;
      z_reg     <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      ctl_reg   <= ctl_next;
      z_reg     <= z_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      dz_reg    <= dz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    ctl_next   = ctl_reg;
    z_next     = z_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    dz_next    = dz_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_next   = bus.bus_in;
          ctl_next = bus.opcode;
          err_next = 1'b0;
          dz_next  = 1'b0;
          if (!op_valid(bus.opcode)) begin
            // Invalid opcodes report through err and leave Z as it was.
            err_next   = 1'b1;
            state_next = OUT_LO;
          end else if (op_unary(bus.opcode)) begin
            b_next     = '0;
            cnt_next   = wait_for(bus.opcode);
            state_next = EXEC;
          end else begin
            state_next = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        b_next = bus.bus_in;
        if ((ctl_reg == OP_DIV) && (bus.bus_in == 32'd0)) begin
          dz_next    = 1'b1;
          z_next     = '0;
          state_next = OUT_LO;
        end else begin
          cnt_next   = wait_for(ctl_reg);
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (cnt_reg <= CW'(1)) begin
          cnt_next   = '0;
          state_next = CAPTURE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      CAPTURE: begin
        z_next     = bus.alu_c;
        state_next = OUT_LO;
      end
      OUT_LO: begin
        state_next = wide_out ? OUT_HI : IDLE;
      end
      OUT_HI: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Only a real (non divide-by-zero) multiply or divide returns the upper word.
  assign wide_out = ((ctl_reg == OP_MUL) || (ctl_reg == OP_DIV)) && !dz_reg;

  assign bus.alu_a     = a_reg;
  assign bus.alu_b     = b_reg;
  assign bus.alu_ctl   = ctl_reg;
  assign bus.z_lo      = z_reg[31:0];
  assign bus.z_hi      = z_reg[63:32];
  assign bus.err       = err_reg;
  assign bus.dz        = dz_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.bus_drive = (state_reg == OUT_LO) || (state_reg == OUT_HI);
  assign bus.done      = ((state_reg == OUT_LO) && !wide_out) || (state_reg == OUT_HI);
  assign bus.bus_out   = (state_reg == OUT_LO) ? z_reg[31:0] :
                         (state_reg == OUT_HI) ? z_reg[63:32] : 32'd0;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MUL_WAIT, default 4, meaning EXEC cycles for multiply (opcode 3).
REQ-002 SHALL have parameter DIV_WAIT, default 32, meaning EXEC cycles for divide (opcode 4).
REQ-003 SHALL have port clk  in  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port clr  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  request; sampled only in IDLE.
REQ-006 SHALL have port opcode  in  4  ALU operation code, sampled with start.
REQ-007 SHALL have port bus_in  in  32  operand source: A with start, B one cycle later.
REQ-008 SHALL have port alu_a  out  32  registered operand A (Y register) to ALU.
REQ-009 SHALL have port alu_b  out  32  registered operand B to ALU.
REQ-010 SHALL have port alu_ctl  out  4  registered opcode to ALU.
REQ-011 SHALL have port alu_c  in  64  combinational ALU result.
REQ-012 SHALL have ports z_lo and z_hi  out  32 each  Z register halves (alu_c[31:0], alu_c[63:32]).
REQ-013 SHALL have port bus_out  out  32  value driven to bus; bus_drive  out  1  qualifies bus_out.
REQ-014 SHALL have ports busy, done, err, dz  out  1 each  status.

Function
REQ-015 Opcodes: 1 add, 2 sub, 3 mul, 4 div, 5 shr, 6 shl, 7 ror, 8 rol, 9 and, 10 or, 11 not, 12 neg; 11 and 12 unary; 0, 13-15 invalid.
REQ-016 States: IDLE, LOAD_B, EXEC, CAPTURE, OUT_LO, OUT_HI.
REQ-017 IDLE with start=1: Y<=bus_in, alu_ctl<=opcode, busy<=1; binary valid op -> LOAD_B; unary op -> EXEC with alu_b<=0; invalid op -> OUT_LO with err<=1, Z unchanged.
REQ-018 LOAD_B: alu_b<=bus_in; opcode 4 with bus_in==0 -> OUT_LO with dz<=1, Z<=64'h0; otherwise -> EXEC.
REQ-019 EXEC: down-counter loaded on entry with 1 (ops 1,2,5-12), MUL_WAIT (3) or DIV_WAIT (4); exit to CAPTURE when counter reaches 1.
REQ-020 CAPTURE: {z_hi,z_lo}<=alu_c; -> OUT_LO.
REQ-021 OUT_LO: bus_out=z_lo, bus_drive=1; ops 3/4 (non-dz) -> OUT_HI; else done=1 this cycle, -> IDLE.
REQ-022 OUT_HI: bus_out=z_hi, bus_drive=1, done=1; -> IDLE.
REQ-023 done is a single-cycle pulse; busy=1 in every state except IDLE, 0 in IDLE including the cycle after done.
REQ-024 err and dz hold from set until the next accepted start, which clears them.
REQ-025 start outside IDLE ignored with no effect on state, operands or flags.
REQ-026 start asserted in the IDLE cycle following done SHALL be accepted (back-to-back).
REQ-027 bus_out=0 whenever bus_drive=0.
REQ-028 Simple binary op latency: start at cycle 0 -> done at cycle 4; unary: cycle 3; mul: cycle 4+MUL_WAIT; div: cycle 4+DIV_WAIT.
REQ-029 Outputs never depend combinationally on alu_c; alu_c used only in CAPTURE.

Reset
REQ-030 clr=1 at a rising edge SHALL force IDLE and zero alu_a, alu_b, alu_ctl, z_lo, z_hi, counter, busy, done, err, dz, bus_drive, bus_out.
REQ-031 clr SHALL take priority over start and over any in-progress state, including mid-EXEC and OUT_HI.
REQ-032 First start accepted on the first edge after clr deasserts.

Verification
REQ-033 Add: start, opcode=1, bus_in=5 then 7, ALU model -> bus_out=12 at cycle 4 with done=1, busy=0 at cycle 5.
REQ-034 Mul: opcode=3, A=32'h0001_0000, B=32'h0001_0000, MUL_WAIT=4 -> cycle 7 bus_out=0 (lo), cycle 8 bus_out=1 (hi) with done=1.
REQ-035 Div by zero: opcode=4, A=9, B=0 -> dz=1, single OUT_LO cycle with bus_out=0 and done=1 at cycle 2, no EXEC.
REQ-036 Invalid opcode 0 -> err=1, done at cycle 1, z_lo/z_hi unchanged from prior op; next valid start clears err.
REQ-037 clr asserted at EXEC count 10 of a divide -> next cycle IDLE, all outputs zero, no done pulse; new add completes normally.
REQ-038 start held high throughout a mul -> ignored while busy, second op accepted in the IDLE cycle after done.
